// File: rtl/scoreboard_pkg.sv
// Shared definitions for scoreboard functional units and the scoreboard decoder.
// Contents:
//   op_e              3-bit opcode encoding shared by all FU variants
//   DIV0_FILL/DIV0_ERR  divide-by-zero policy: result bits all DIV0_FILL, err flag DIV0_ERR
package scoreboard_pkg;

    localparam int OP_BITS = 3;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_SLL = 3'd7
    } op_e;

    // Division by zero returns a zero result and raises the error flag
    localparam logic DIV0_FILL = 1'b0;
    localparam logic DIV0_ERR  = 1'b1;

endpackage

// File: rtl/pipelined_exec_unit_if.sv
// Issue and result handshake bundle between the scoreboard operand stage
// (master) and an execution unit (slave).
// Signals:
//   in_valid/in_ready          issue handshake; in_op/in_dest/in_tag/in_a/in_b payload
//   out_valid/out_ready        result handshake; out_dest/out_tag/out_data/out_err payload
interface pipelined_exec_unit_if
    import scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5,
    parameter int TAG_BITS   = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_BITS-1:0]    in_op;
    logic [REG_BITS-1:0]   in_dest;
    logic [TAG_BITS-1:0]   in_tag;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;

    logic                  out_valid;
    logic                  out_ready;
    logic [REG_BITS-1:0]   out_dest;
    logic [TAG_BITS-1:0]   out_tag;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_err;

    modport master (
        output in_valid, in_op, in_dest, in_tag, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_dest, out_tag, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_dest, in_tag, in_a, in_b, out_ready,
        output in_ready, out_valid, out_dest, out_tag, out_data, out_err
    );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the pipelined execution unit.
// Ports:
//   op_i      opcode (scoreboard_pkg::op_e encoding)
//   a_i, b_i  operands
//   result_o  result, wrapped to DATA_WIDTH bits
//   err_o     set only for DIV with b_i == 0
module exec_alu
    import scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [OP_BITS-1:0]    op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  err_o
);
    localparam int SHAMT_BITS = $clog2(DATA_WIDTH);

    logic [SHAMT_BITS-1:0] shamt;
    assign shamt = b_i[SHAMT_BITS-1:0];

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (op_e'(op_i))
            OP_ADD: result_o = a_i + b_i;
            OP_SUB: result_o = a_i - b_i;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_MUL: result_o = a_i * b_i;
            OP_DIV: begin
                if (b_i == '0) begin
                    result_o = {DATA_WIDTH{DIV0_FILL}};
                    err_o    = DIV0_ERR;
                end else begin
                    result_o = a_i / b_i;
                end
            end
            OP_SLL: result_o = a_i << shamt;
            default: ;
        endcase
    end
endmodule

// File: rtl/pipelined_exec_unit.sv
// Fully pipelined scoreboard functional unit: LATENCY stages, one op per cycle,
// valid/ready on issue and result with whole-pipeline stall on backpressure.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush            clears every stage valid on the next edge, drops same-cycle issue
//   io (slave)       issue / result handshake bundle
//   inflight_count   number of occupied stages (registered)
//   busy             inflight_count != 0
module pipelined_exec_unit
    import scoreboard_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int REG_BITS   = 5,
    parameter  int TAG_BITS   = 3,
    parameter  int LATENCY    = 4,
    localparam int CNT_BITS   = $clog2(LATENCY + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    pipelined_exec_unit_if.slave io,
    output logic [CNT_BITS-1:0] inflight_count,
    output logic                busy
);
    localparam int LAST = LATENCY - 1;

    logic                  stall;
    logic                  accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_err;

    logic                  valid_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_q  [LATENCY];
    logic [REG_BITS-1:0]   dest_q  [LATENCY];
    logic [TAG_BITS-1:0]   tag_q   [LATENCY];
    logic                  err_q   [LATENCY];
    logic [CNT_BITS-1:0]   cnt_q;
    logic [CNT_BITS-1:0]   cnt_d;

    assign stall       = valid_q[LAST] & ~io.out_ready;
    assign io.in_ready = ~stall & ~flush;
    assign accept      = io.in_valid & io.in_ready;
    assign xfer        = valid_q[LAST] & io.out_ready;

    exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i     (io.in_op),
        .a_i      (io.in_a),
        .b_i      (io.in_b),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    // Payload registers only load behind a valid so idle-bus X never enters
    // the pipeline and the output holds its last value between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                dest_q[i]  <= '0;
                tag_q[i]   <= '0;
                err_q[i]   <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            valid_q[0] <= accept;
            if (accept) begin
                data_q[0] <= alu_result;
                dest_q[0] <= io.in_dest;
                tag_q[0]  <= io.in_tag;
                err_q[0]  <= alu_err;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                    dest_q[i] <= dest_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                    err_q[i]  <= err_q[i-1];
                end
            end
        end
    end

    // Tracks the stage-valid population: under stall neither accept nor xfer
    // can happen, otherwise the op leaving the last stage is exactly xfer.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept && !xfer) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && xfer) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign io.out_valid   = valid_q[LAST];
    assign io.out_data    = data_q[LAST];
    assign io.out_dest    = dest_q[LAST];
    assign io.out_tag     = tag_q[LAST];
    assign io.out_err     = err_q[LAST];
    assign inflight_count = cnt_q;
    assign busy           = (cnt_q != '0);
endmodule
